dmem_line_server: RTL and testbench

- Cache-line memory responder for the external D-memory port that the Aquila SoC drives (strobe/addr/rw/line-data/done).
- Serves whole-line reads and writes from an internal word-wide single-port SRAM.
- Inserts a programmable access latency and moves the line one word per clock.
- Used as the simulation and FPGA backing store behind the D-cache/atomic unit, in place of the DDRx controller.

---
 rtl/dmem_line_server_if.sv | 28 ++
 rtl/dmem_line_server.sv | 153 +++++++++++++++
 tb/tb_dmem_line_server.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_line_server_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_server_if
//  Purpose  : Cache-line D-memory port between an initiator (D-cache/atomic
//             unit) and the line server.
//  Signals  : strobe - request valid (initiator)
//             addr   - byte address of the line (initiator)
//             rw     - 1 = write line, 0 = read line (initiator)
//             wdata  - write line data (initiator)
//             done   - one-cycle completion pulse (server)
//             rdata  - read line data (server)
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_line_server_if #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 128
);
  logic              strobe;
  logic [XLEN-1:0]   addr;
  logic              rw;
  logic [CLSIZE-1:0] wdata;
  logic              done;
  logic [CLSIZE-1:0] rdata;

  modport master (output strobe, addr, rw, wdata, input  done, rdata);
  modport slave  (input  strobe, addr, rw, wdata, output done, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_line_server.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_server
//  Purpose  : Whole-line read/write responder backed by a word-wide
//             single-port SRAM. After a programmable latency the line is
//             moved one word per clock, then done pulses for one cycle.
//  Ports    : clk_i - clock, rising edge
//             rst_i - asynchronous active-low reset (SRAM not cleared)
//             bus   - dmem_line_server_if.slave line port
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_line_server #(
  parameter int XLEN      = 32,
  parameter int CLSIZE    = 128,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dmem_line_server_if.slave  bus
);

  localparam int c_BEATS = CLSIZE / XLEN;
  localparam int c_BW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_AW    = $clog2(MEM_WORDS);
  localparam int c_OFF   = $clog2(XLEN / 8);

  localparam logic [c_AW-1:0] c_LINE_MASK = ~c_AW'(c_BEATS - 1);
  localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_BEATS - 1);
  localparam logic [7:0]      c_LAT_LAST  = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_WAIT  = 3'd1;
  localparam logic [2:0] c_ST_XFER  = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [7:0]        r_wait_cnt;
  logic [c_BW-1:0]   r_beat;
  logic [c_AW-1:0]   r_base;
  logic              r_rw;
  logic [CLSIZE-1:0] r_wdata;
  logic              r_done;
  logic [CLSIZE-1:0] r_rdata;

  logic [XLEN-1:0]   r_mem  [MEM_WORDS];
  logic [XLEN-1:0]   r_sram_q;
  logic [XLEN-1:0]   r_lbuf [c_BEATS];

  logic [XLEN-1:0]   w_addr_word;
  logic              w_unused_addr;
  logic [c_AW-1:0]   w_req_base;
  logic [c_AW-1:0]   w_sram_addr;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [XLEN-1:0]   w_wbeat [c_BEATS];
  logic [CLSIZE-1:0] w_rline;

  // Word index of the request; bits above the SRAM depth wrap silently.
  assign w_addr_word   = bus.addr >> c_OFF;
  assign w_unused_addr = ^w_addr_word;
  assign w_req_base    = w_addr_word[c_AW-1:0] & c_LINE_MASK;

  // Base is line-aligned, so OR-ing in the beat index never carries.
  assign w_sram_addr = r_base | c_AW'(r_beat);
  assign w_wr_en     = (r_state == c_ST_XFER) &&  r_rw;
  assign w_rd_en     = (r_state == c_ST_XFER) && !r_rw;

  // Beat k of the write line is slice k; the read line is assembled from the
  // staging buffer plus the last SRAM output, which arrives in DRAIN.
  for (genvar k = 0; k < c_BEATS; k++) begin : g_beat
    assign w_wbeat[k] = r_wdata[k*XLEN +: XLEN];
    if (k == c_BEATS - 1) begin : g_last
      assign w_rline[k*XLEN +: XLEN] = r_sram_q;
    end else begin : g_buf
      assign w_rline[k*XLEN +: XLEN] = r_lbuf[k];
    end
  end

  // SRAM: one access per cycle, synchronous read.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_sram_addr] <= w_wbeat[r_beat];
    if (w_rd_en) r_sram_q <= r_mem[w_sram_addr];
  end

  // The SRAM output for beat k-1 is valid while beat k is being addressed.
  always_ff @(posedge clk_i) begin
    if (w_rd_en && (r_beat != '0)) r_lbuf[r_beat - 1'b1] <= r_sram_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= c_ST_IDLE;
      r_wait_cnt <= '0;
      r_beat     <= '0;
      r_base     <= '0;
      r_rw       <= 1'b0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.strobe) begin
            r_base     <= w_req_base;
            r_rw       <= bus.rw;
            r_wdata    <= bus.wdata;
            r_wait_cnt <= '0;
            r_beat     <= '0;
            r_state    <= (LATENCY == 0) ? c_ST_XFER : c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (r_wait_cnt == c_LAT_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= c_ST_XFER;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        c_ST_XFER: begin
          if (r_beat == c_LAST_BEAT) begin
            r_beat  <= '0;
            r_state <= c_ST_DRAIN;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        c_ST_DRAIN: begin
          // Read data is published only here so it holds until the next
          // read completes; writes leave it untouched.
          if (!r_rw) r_rdata <= w_rline;
          r_done  <= 1'b1;
          r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_line_server
//  Purpose  : Self-checking bench for dmem_line_server. Three servers with
//             latencies 4, 0 and 7 share the request inputs; a line-level
//             reference memory supplies the expected read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_line_server;

  localparam int XLEN      = 32;
  localparam int CLSIZE    = 128;
  localparam int BEATS     = CLSIZE / XLEN;
  localparam int MEM_WORDS = 4096;

  logic              clk = 1'b0;
  logic              rst_main;
  logic              rst_aux;
  logic              aux_en;
  logic              strobe;
  logic [XLEN-1:0]   addr;
  logic              rw;
  logic [CLSIZE-1:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_line_server_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus4 ();
  dmem_line_server_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus0 ();
  dmem_line_server_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus7 ();

  assign bus4.strobe = strobe;
  assign bus0.strobe = strobe & aux_en;
  assign bus7.strobe = strobe & aux_en;
  assign bus4.addr = addr;  assign bus0.addr = addr;  assign bus7.addr = addr;
  assign bus4.rw   = rw;    assign bus0.rw   = rw;    assign bus7.rw   = rw;
  assign bus4.wdata = wdata; assign bus0.wdata = wdata; assign bus7.wdata = wdata;

  dmem_line_server #(.XLEN(XLEN), .CLSIZE(CLSIZE), .MEM_WORDS(MEM_WORDS), .LATENCY(4))
    dut4 (.clk_i(clk), .rst_i(rst_main), .bus(bus4));
  dmem_line_server #(.XLEN(XLEN), .CLSIZE(CLSIZE), .MEM_WORDS(MEM_WORDS), .LATENCY(0))
    dut0 (.clk_i(clk), .rst_i(rst_aux), .bus(bus0));
  dmem_line_server #(.XLEN(XLEN), .CLSIZE(CLSIZE), .MEM_WORDS(MEM_WORDS), .LATENCY(7))
    dut7 (.clk_i(clk), .rst_i(rst_aux), .bus(bus7));

  // ---------------- reference model ----------------
  logic [XLEN-1:0]   mref [int unsigned];
  logic [CLSIZE-1:0] last_rd;
  int                lat [3];
  logic [CLSIZE-1:0] rd  [3];
  int                exp_lat [3] = '{10, 6, 13};

  function automatic int unsigned mbase(input logic [31:0] a);
    return ((a / 4) / BEATS * BEATS) % MEM_WORDS;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [CLSIZE-1:0] d);
    int unsigned b = mbase(a);
    for (int k = 0; k < BEATS; k++) mref[b + k] = d[k*XLEN +: XLEN];
  endtask

  function automatic logic [CLSIZE-1:0] model_read(input logic [31:0] a);
    logic [CLSIZE-1:0] l;
    int unsigned b = mbase(a);
    l = 'x;
    for (int k = 0; k < BEATS; k++)
      if (mref.exists(b + k)) l[k*XLEN +: XLEN] = mref[b + k];
    return l;
  endfunction

  task automatic check(input string tag, input logic [CLSIZE-1:0] obs, input logic [CLSIZE-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and record done cycle/read data for every active server.
  task automatic run_req(input logic op_rw, input logic [31:0] op_addr, input logic [CLSIZE-1:0] op_data);
    logic [2:0] seen, want;
    want = aux_en ? 3'b111 : 3'b001;
    seen = '0;
    lat  = '{-1, -1, -1};
    strobe = 1'b1; rw = op_rw; addr = op_addr; wdata = op_data;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus4.done && !seen[0]) begin seen[0] = 1'b1; lat[0] = n; rd[0] = bus4.rdata; end
      if (bus0.done && !seen[1]) begin seen[1] = 1'b1; lat[1] = n; rd[1] = bus0.rdata; end
      if (bus7.done && !seen[2]) begin seen[2] = 1'b1; lat[2] = n; rd[2] = bus7.rdata; end
      if ((seen & want) == want) break;
      @(posedge clk); #1;
      // Scramble inputs after capture; the request must be unaffected.
      strobe = 1'b0; rw = 1'($urandom); addr = $urandom;
      wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    strobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string tag, input logic op_rw, input logic [31:0] op_addr,
                       input logic [CLSIZE-1:0] op_data);
    logic [CLSIZE-1:0] exp_rd;
    run_req(op_rw, op_addr, op_data);
    if (op_rw) begin
      model_write(op_addr, op_data);
      exp_rd = last_rd;
    end else begin
      exp_rd  = model_read(op_addr);
      last_rd = exp_rd;
    end
    for (int i = 0; i < (aux_en ? 3 : 1); i++) begin
      check($sformatf("%s lat[%0d]", tag, i), CLSIZE'(lat[i]), CLSIZE'(exp_lat[i]));
      check($sformatf("%s data[%0d]", tag, i), rd[i], exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]       lines [6];
    logic [CLSIZE-1:0] old_line, new_line;
    int n1, n2, dcnt;

    rst_main = 1'b0; rst_aux = 1'b0; aux_en = 1'b1;
    strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0; last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", CLSIZE'(bus4.done), '0);
    check("reset rdata", bus4.rdata, '0);
    rst_main = 1'b1; rst_aux = 1'b1;
    @(posedge clk); #1;

    // Write then read a line; inspect word placement in the SRAM.
    do_op("wr 0x10", 1'b1, 32'h8000_0010, 128'h44444444_33333333_22222222_11111111);
    for (int k = 0; k < BEATS; k++)
      check($sformatf("sram word %0d", 4 + k), CLSIZE'(dut4.r_mem[4 + k]), CLSIZE'(32'h11111111 * (k + 1)));
    do_op("rd 0x10", 1'b0, 32'h8000_0010, '0);
    do_op("rd 0x1C", 1'b0, 32'h8000_001C, '0);

    // Address wrap-around.
    do_op("wr 0x4000", 1'b1, 32'h0000_4000, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0);
    do_op("rd 0x0", 1'b0, 32'h0000_0000, '0);

    // Randomised traffic across a handful of lines with aliased addresses.
    for (int i = 0; i < 6; i++) begin
      lines[i] = $urandom;
      do_op("prime", 1'b1, lines[i], {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < 16; i++) begin
      int idx = $urandom_range(0, 5);
      logic [31:0] a = lines[idx] ^ ($urandom & 32'hFFFF_C00F);
      do_op($sformatf("rand%0d", i), 1'($urandom), a, {$urandom, $urandom, $urandom, $urandom});
    end

    // From here on only the LATENCY=4 server is exercised.
    aux_en = 1'b0;

    // Strobe held high across two reads.
    n1 = -1; n2 = -1;
    strobe = 1'b1; rw = 1'b0; addr = 32'h8000_0010;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus4.done) begin
        if (n1 < 0) begin n1 = n; rd[0] = bus4.rdata; end
        else begin n2 = n; strobe = 1'b0; break; end
      end
      @(posedge clk); #1;
    end
    strobe = 1'b0;
    @(posedge clk); #1;
    last_rd = model_read(32'h8000_0010);
    check("held first done", CLSIZE'(n1), CLSIZE'(10));
    check("held done spacing", CLSIZE'(n2 - n1), CLSIZE'(11));
    check("held data", rd[0], last_rd);

    // A strobe pulse (write to another line) during WAIT must be ignored.
    n1 = -1;
    strobe = 1'b1; rw = 1'b0; addr = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus4.done) begin n1 = n; rd[0] = bus4.rdata; break; end
      @(posedge clk); #1;
      strobe = (n + 1 == 2);
      rw = 1'b1; addr = 32'h8000_0010; wdata = '1;
    end
    strobe = 1'b0;
    @(posedge clk); #1;
    last_rd = model_read(32'h0);
    check("glitch done", CLSIZE'(n1), CLSIZE'(10));
    check("glitch data", rd[0], last_rd);
    do_op("after glitch", 1'b0, 32'h8000_0010, '0);

    // Reset in the middle of a write: two beats committed, rest untouched.
    old_line = {$urandom, $urandom, $urandom, $urandom};
    new_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    do_op("abort old", 1'b1, 32'h0000_0100, old_line);
    strobe = 1'b1; rw = 1'b1; addr = 32'h0000_0100; wdata = new_line;
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_main = 1'b0;
    #1;
    check("abort done", CLSIZE'(bus4.done), '0);
    check("abort rdata", bus4.rdata, '0);
    mref[mbase(32'h100) + 0] = new_line[31:0];
    mref[mbase(32'h100) + 1] = new_line[63:32];
    last_rd = '0;
    @(negedge clk);
    rst_main = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus4.done) dcnt++;
    end
    check("abort no done", CLSIZE'(dcnt), '0);
    @(posedge clk); #1;
    do_op("abort read", 1'b0, 32'h0000_0100, '0);
    check("abort mix", rd[0], {old_line[127:64], new_line[63:0]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
